// File: rtl/pcie_msi_pkg.sv
// rtl/pcie_msi_pkg.sv - shared state encoding, TLP header constants and MSI vector helper
package pcie_msi_pkg;

  typedef enum logic [2:0] {
    IDLE, MSI_H01, MSI_H2, MSI_H3D, INT_H01, INT_H23, ACK, GAP
  } msi_state_t;

  localparam logic [2:0] FMT_3DW_D  = 3'b010;
  localparam logic [2:0] FMT_4DW_D  = 3'b011;
  localparam logic [2:0] FMT_4DW_ND = 3'b001;

  localparam logic [4:0] TYPE_MWR       = 5'b00000;
  localparam logic [4:0] TYPE_MSG_LOCAL = 5'b10100;

  localparam logic [7:0] MSG_ASSERT_INTA   = 8'h20;
  localparam logic [7:0] MSG_DEASSERT_INTA = 8'h24;

  // mme must already be clamped to the supported maximum by the caller
  function automatic logic [15:0] msi_vector(input logic [15:0] data,
                                             input logic [4:0]  num,
                                             input logic [2:0]  mme);
    logic [15:0] mask;
    mask = (16'h0001 << mme) - 16'h0001;
    return (data & ~mask) | ({11'h000, num} & mask);
  endfunction

endpackage

// File: rtl/pcie_msi_responder_if.sv
// rtl/pcie_msi_responder_if.sv - 64-bit TLP source stream with valid/ready handshake
interface pcie_msi_responder_if;
  logic [63:0] tx_data;
  logic        tx_sop;
  logic        tx_eop;
  logic        tx_valid;
  logic        tx_ready;

  modport master (output tx_data, output tx_sop, output tx_eop, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_sop, input tx_eop, input tx_valid, output tx_ready);
endinterface

// File: rtl/pcie_msi_tlp_hdr.sv
// rtl/pcie_msi_tlp_hdr.sv - combinational builder of MSI MemWr / INTx message header DWs
module pcie_msi_tlp_hdr
  import pcie_msi_pkg::*;
(
  input  logic        is_msi,
  input  logic [2:0]  tc,
  input  logic [15:0] req_id,
  input  logic [15:0] vector,
  input  logic [7:0]  msg_code,
  input  logic [63:0] addr,
  output logic [31:0] dw0,
  output logic [31:0] dw1,
  output logic [31:0] dw2,
  output logic [31:0] dw3,
  output logic [31:0] data_dw,
  output logic        is_4dw
);

  logic [31:0] addr_lo;

  always_comb begin
    addr_lo = addr[31:0] & 32'hFFFF_FFFC;
    data_dw = {16'h0000, vector};
    is_4dw  = is_msi && (addr[63:32] != 32'h0);
    dw0 = '0;
    dw1 = '0;
    dw2 = '0;
    dw3 = '0;
    if (is_msi) begin
      dw0 = {(is_4dw ? FMT_4DW_D : FMT_3DW_D), TYPE_MWR, 1'b0, tc, 10'h000, 10'd1};
      dw1 = {req_id, 8'h00, 4'h0, 4'hF};
      // 3DW form carries the data DW in the DW3 slot so beat 2 is always {dw3, dw2}
      dw2 = is_4dw ? addr[63:32] : addr_lo;
      dw3 = is_4dw ? addr_lo : data_dw;
    end else begin
      dw0 = {FMT_4DW_ND, TYPE_MSG_LOCAL, 1'b0, 3'b000, 10'h000, 10'd0};
      dw1 = {req_id, 8'h00, msg_code};
    end
  end

endmodule

// File: rtl/pcie_msi_responder.sv
// rtl/pcie_msi_responder.sv - turns MSI requests and INTA level changes into TLPs on a 64-bit stream
module pcie_msi_responder
  import pcie_msi_pkg::*;
#(
  parameter int MSI_MAX_LOG2   = 3,
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        app_msi_req,
  input  logic [4:0]                  app_msi_num,
  input  logic [2:0]                  app_msi_tc,
  output logic                        app_msi_ack,
  input  logic                        app_int_sts,
  output logic                        app_int_ack,
  input  logic                        msi_enable,
  input  logic [2:0]                  msi_mme,
  input  logic [63:0]                 msi_addr,
  input  logic [15:0]                 msi_data,
  input  logic [15:0]                 requester_id,
  pcie_msi_responder_if.master        tx,
  output logic                        err_drop
);

  localparam logic [31:0] TIMEOUT = 32'(TIMEOUT_CYCLES);
  localparam logic [2:0]  MME_MAX = 3'(MSI_MAX_LOG2);

  msi_state_t  state, state_nxt;
  logic        int_last;
  logic        served_msi;
  logic [2:0]  lat_tc;
  logic [15:0] lat_id;
  logic [15:0] lat_vec;
  logic [7:0]  lat_code;
  logic [63:0] lat_addr;
  logic [31:0] wait_cnt;

  logic        int_go, msi_go, wait_on, drop_go;
  logic [2:0]  mme_eff;
  logic [31:0] dw0, dw1, dw2, dw3, data_dw;
  logic        is_4dw;

  // INTx wins only while MSI is disabled
  assign int_go  = (app_int_sts != int_last) && !msi_enable;
  assign msi_go  = app_msi_req && msi_enable;
  assign wait_on = app_msi_req && !msi_enable && !int_go;
  assign drop_go = wait_on && (TIMEOUT != 32'h0) && (wait_cnt == TIMEOUT);
  assign mme_eff = (msi_mme > MME_MAX) ? MME_MAX : msi_mme;

  pcie_msi_tlp_hdr u_hdr (
    .is_msi   (served_msi),
    .tc       (lat_tc),
    .req_id   (lat_id),
    .vector   (lat_vec),
    .msg_code (lat_code),
    .addr     (lat_addr),
    .dw0      (dw0),
    .dw1      (dw1),
    .dw2      (dw2),
    .dw3      (dw3),
    .data_dw  (data_dw),
    .is_4dw   (is_4dw)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      int_last   <= 1'b0;
      served_msi <= 1'b0;
      lat_tc     <= '0;
      lat_id     <= '0;
      lat_vec    <= '0;
      lat_code   <= '0;
      lat_addr   <= '0;
      wait_cnt   <= '0;
      err_drop   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE) begin
        if (int_go) begin
          int_last   <= app_int_sts;
          served_msi <= 1'b0;
          lat_id     <= requester_id;
          lat_code   <= app_int_sts ? MSG_ASSERT_INTA : MSG_DEASSERT_INTA;
        end else if (msi_go) begin
          served_msi <= 1'b1;
          lat_tc     <= app_msi_tc;
          lat_id     <= requester_id;
          lat_addr   <= msi_addr;
          lat_vec    <= msi_vector(msi_data, app_msi_num, mme_eff);
        end else if (drop_go) begin
          served_msi <= 1'b1;
          err_drop   <= 1'b1;
        end
        // an INTx message in front of a waiting request keeps its count
        if (wait_on && !drop_go && (TIMEOUT != 32'h0))
          wait_cnt <= wait_cnt + 32'd1;
        else if (!int_go)
          wait_cnt <= '0;
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    tx.tx_valid = 1'b0;
    tx.tx_sop   = 1'b0;
    tx.tx_eop   = 1'b0;
    tx.tx_data  = '0;
    app_msi_ack = 1'b0;
    app_int_ack = 1'b0;
    case (state)
      IDLE: begin
        if (int_go)       state_nxt = INT_H01;
        else if (msi_go)  state_nxt = MSI_H01;
        else if (drop_go) state_nxt = ACK;
      end
      MSI_H01, INT_H01: begin
        tx.tx_valid = 1'b1;
        tx.tx_sop   = 1'b1;
        tx.tx_data  = {dw1, dw0};
        if (tx.tx_ready) state_nxt = (state == MSI_H01) ? MSI_H2 : INT_H23;
      end
      MSI_H2, INT_H23: begin
        tx.tx_valid = 1'b1;
        tx.tx_eop   = !is_4dw;
        tx.tx_data  = {dw3, dw2};
        if (tx.tx_ready) state_nxt = is_4dw ? MSI_H3D : ACK;
      end
      MSI_H3D: begin
        tx.tx_valid = 1'b1;
        tx.tx_eop   = 1'b1;
        tx.tx_data  = {32'h0, data_dw};
        if (tx.tx_ready) state_nxt = ACK;
      end
      ACK: begin
        app_msi_ack = served_msi;
        app_int_ack = !served_msi;
        state_nxt   = GAP;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
